// File: rtl/four_bit_comp_bist_if.sv
`default_nettype none
// ============================================================================
//  Module      : four_bit_comp_bist_if
//  Description : Operand/flag bundle between the comparator self-test driver
//                (master: drives A/B, observes E/L/G) and the comparator
//                under test (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface four_bit_comp_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             E;
  logic             L;
  logic             G;

  // Self-test side: owns the operands, listens to the flags
  modport master (output A, output B, input E, input L, input G);

  // Comparator side: consumes the operands, produces the flags
  modport slave  (input A, input B, output E, output L, output G);
endinterface
`default_nettype wire

// File: rtl/four_bit_comp_bist.sv
`default_nettype none
// ============================================================================
//  Module      : four_bit_comp_bist
//  Description : Exhaustive self-test driver/checker for a WIDTH-bit magnitude
//                comparator. Sweeps every (A,B) pair with B fastest, lets each
//                pair settle for SETTLE cycles, checks E/L/G against the
//                unsigned relation, counts failures and captures the first.
//  Revision    : 1.0  initial release
// ============================================================================
module four_bit_comp_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               start,
  four_bit_comp_bist_if.master    cmp,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [2*WIDTH:0]        err_count,
  output logic                    fail_valid,
  output logic [WIDTH-1:0]        fail_A,
  output logic [WIDTH-1:0]        fail_B,
  output logic [2:0]              fail_elg
);

  localparam int c_idx_w  = 2 * WIDTH;
  localparam int c_wait_w = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [c_wait_w-1:0] c_settle = c_wait_w'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_idx_w-1:0]  r_idx;
  logic [c_wait_w-1:0] r_wait;

  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;
  logic [2:0]          w_obs;
  logic [2:0]          w_exp;
  logic                w_mismatch;
  logic                w_last;
  logic [2*WIDTH:0]    w_err_next;

  // Operands come straight from the registered vector index, so A/B are
  // glitch-free and stable for the whole settle window.
  assign w_a   = r_idx[c_idx_w-1:WIDTH];
  assign w_b   = r_idx[WIDTH-1:0];
  assign cmp.A = w_a;
  assign cmp.B = w_b;

  // Any deviation from the one-hot reference is a failure, which also
  // catches all-zero and multi-hot flag patterns.
  assign w_obs      = {cmp.E, cmp.L, cmp.G};
  assign w_exp      = {(w_a == w_b), (w_a < w_b), (w_a > w_b)};
  assign w_mismatch = (w_obs != w_exp);
  assign w_last     = &r_idx;
  assign w_err_next = err_count + {{(2*WIDTH){1'b0}}, w_mismatch};

  // Sweep sequencer: IDLE/DONE wait for start, WAIT holds operands, CHECK scores one vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_wait     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_A     <= '0;
      fail_B     <= '0;
      fail_elg   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_idx      <= '0;
            r_wait     <= c_settle;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_A     <= '0;
            fail_B     <= '0;
            fail_elg   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait - 1'b1;
          if (r_wait == c_wait_w'(1)) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_count <= w_err_next;
          if (w_mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_A     <= w_a;
            fail_B     <= w_b;
            fail_elg   <= w_obs;
          end
          if (w_last) begin
            // Final verdict must include the vector being scored this cycle
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_next == '0);
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_wait  <= c_settle;
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/four_bit_comp_bist.md
Name: four_bit_comp_bist

Overview:
- Self-test driver/checker for the magnitude comparator: the opposite end of its A/B → E/L/G interface.
- Generates every (A,B) pair, drives A/B to the comparator, samples E/L/G after a settle delay and checks them against the expected relation.
- Counts mismatches and captures the first failing vector.
- Sits beside the comparator in the test wrapper; controlled by a start/done handshake.

Parameters:
- WIDTH, 4: operand width of A and B.
- SETTLE, 1: cycles (≥1) A/B are held in WAIT before E/L/G are sampled.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- A  output  WIDTH  operand A to comparator (registered).
- B  output  WIDTH  operand B to comparator (registered).
- E  input  1  comparator equal flag.
- L  input  1  comparator less-than flag (A<B).
- G  input  1  comparator greater-than flag (A>B).
- busy  output  1  sweep in progress (WAIT or CHECK).
- done  output  1  sweep finished; held until next start or reset.
- pass  output  1  done and err_count==0.
- err_count  output  2*WIDTH+1  number of failing vectors.
- fail_valid  output  1  a failure has been captured.
- fail_A  output  WIDTH  A of first failing vector.
- fail_B  output  WIDTH  B of first failing vector.
- fail_elg  output  3  {E,L,G} observed on first failing vector.

Behaviour:
- Async reset: state=IDLE; A, B, err_count, fail_A, fail_B, fail_elg, fail_valid, busy, done, pass all 0; idx=0.
- idx: 2*WIDTH-bit vector index. A=idx[2W-1:W], B=idx[W-1:0]. Sweep order 0 → 2^(2W)-1 (A=0,B=0 first; B increments fastest).
- IDLE: on start=1:
  - idx=0, A=B=0.
  - clear err_count, fail_valid and fail_* fields.
  - wait_cnt=SETTLE; go to WAIT.
- WAIT: decrement wait_cnt each cycle; after SETTLE cycles go to CHECK. busy=1.
- CHECK (one cycle): sample E/L/G.
  - Expected: E=(A==B), L=(A<B), G=(A>B), all unsigned.
  - Failure: any flag differs from expected. This covers non-one-hot outputs (all 0, or more than one high).
  - On failure: err_count+1. If fail_valid=0, capture fail_A/fail_B/fail_elg and set fail_valid=1.
  - If idx is all-ones, go to DONE.
  - Otherwise idx+1, update A/B, wait_cnt=SETTLE, go to WAIT.
- DONE: busy=0, done=1, pass=(err_count==0). On start=1, re-enter the sweep exactly as from IDLE (done/pass drop the next cycle).
- Timing, start sampled at edge k:
  - vector n is checked at edge k+(n+1)(SETTLE+1).
  - done rises at edge k+2^(2W)(SETTLE+1); WIDTH=4, SETTLE=1 gives k+512.
  - A/B are stable SETTLE+1 cycles before each sample.
- err_count width holds the full 2^(2W) range; no saturation or wrap.
- start while busy: ignored, no restart, no counter change.
- Reset mid-sweep: immediate return to reset values; no partial result retained.
- Flags: done and pass are never high while busy=1. pass is only meaningful with done=1 and is forced 0 otherwise.

Test Plan:
- Correct comparator connected, WIDTH=4, SETTLE=1, start pulse at edge k -> done=1 and pass=1 at edge k+512, err_count=0, fail_valid=0, busy high for 512 cycles.
- Faulty comparator with E stuck at 0 -> err_count=16, fail_valid=1, fail_A=0000, fail_B=0000, fail_elg=000, pass=0.
- Comparator with L and G swapped -> err_count=240, first fail fail_A=0000, fail_B=0001, fail_elg=001, pass=0.
- Assert rst for 1 cycle at vector 100 (A=0110, B=0100) -> all outputs 0 and state IDLE immediately. A new start then gives the full 512-cycle sweep with pass=1.
- start re-pulsed at cycles 50 and 300 of a sweep -> ignored; done still at k+512. start in DONE -> done falls next cycle, new sweep completes 512 cycles later.
- SETTLE=3 with a correct comparator -> done at k+1024, pass=1. Each A/B value held exactly 4 cycles; check the A=1111, B=1111 vector (E=1) last.
